// File: rtl/hidden_2_layer_input_streamer.sv
// Captures one hidden-2 activation vector and streams it as back-to-back
// (activation, weight-address) beats, followed by a bias beat that carries 1.0.
module hidden_2_layer_input_streamer #(
    parameter int DATA_WIDTH           = 32,
    parameter int NUMBER_OF_INPUT_NODE = 32,
    parameter int ADDR_WIDTH           = 6
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       i_valid,
    input  logic [DATA_WIDTH*NUMBER_OF_INPUT_NODE-1:0] i_data,
    output logic                                       o_ready,
    output logic                                       o_weight_rd_en,
    output logic [ADDR_WIDTH-1:0]                      o_weight_addr,
    output logic [DATA_WIDTH-1:0]                      o_data,
    output logic                                       o_valid,
    output logic                                       o_last
);

    localparam int IDX_W = (NUMBER_OF_INPUT_NODE > 1) ? $clog2(NUMBER_OF_INPUT_NODE) : 1;
    localparam logic [ADDR_WIDTH-1:0] BIAS_IDX = ADDR_WIDTH'(NUMBER_OF_INPUT_NODE);
    localparam logic [DATA_WIDTH-1:0] FP_ONE   = DATA_WIDTH'(32'h3F80_0000);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic                    load;
    logic                    rd_en;
    logic [DATA_WIDTH-1:0]   act_q [NUMBER_OF_INPUT_NODE];
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q;
    logic                    last_q;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        rd_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rd_en = 1'b1;
                if (idx_q == BIAS_IDX) begin
                    idx_d   = '0;
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: the activation file is reset on purpose so an abandoned frame leaves no stale data behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUMBER_OF_INPUT_NODE; k++) begin
                act_q[k] <= '0;
            end
        end else if (load) begin
            for (int k = 0; k < NUMBER_OF_INPUT_NODE; k++) begin
                act_q[k] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The beat is registered one cycle after its address so it lines up with the memory read data.
    always_comb begin
        data_d = '0;
        if (rd_en) begin
            if (idx_q == BIAS_IDX) begin
                data_d = FP_ONE;
            end else begin
                data_d = act_q[idx_q[IDX_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= rd_en;
            last_q  <= rd_en && (idx_q == BIAS_IDX);
            data_q  <= data_d;
        end
    end

    assign o_ready        = (state_q == IDLE);
    assign o_weight_rd_en = rd_en;
    assign o_weight_addr  = idx_q;
    assign o_valid        = valid_q;
    assign o_last         = last_q;
    assign o_data         = data_q;

endmodule

// File: tb/tb_hidden_2_layer_input_streamer.sv
// Directed bench: a per-cycle expectation table replayed for each frame, plus
// hand-written sequences for busy requests, back-to-back frames and mid-frame reset.
module tb_hidden_2_layer_input_streamer;

    localparam int DW = 32;
    localparam int N  = 32;
    localparam int AW = 6;
    localparam int W  = DW * N;
    localparam int FRAME_CYCLES = N + 3;

    logic          clk;
    logic          rst_n;
    logic          i_valid;
    logic [W-1:0]  i_data;
    logic          o_ready;
    logic          o_weight_rd_en;
    logic [AW-1:0] o_weight_addr;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_last;
    logic [DW-1:0] w_rdata;

    int total;
    int bad;

    typedef struct {
        bit ready;
        bit rd_en;
        int addr;
        bit valid;
        bit last;
        int beat;
    } row_t;

    row_t tbl [1:FRAME_CYCLES];

    hidden_2_layer_input_streamer #(
        .DATA_WIDTH          (DW),
        .NUMBER_OF_INPUT_NODE(N),
        .ADDR_WIDTH          (AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .o_ready       (o_ready),
        .o_weight_rd_en(o_weight_rd_en),
        .o_weight_addr (o_weight_addr),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_last        (o_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Weight memory: synchronous read, one cycle latency, word k = A000_0000 | k.
    always @(posedge clk) begin
        if (o_weight_rd_en) w_rdata <= 32'hA000_0000 | 32'(o_weight_addr);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic logic [31:0] int_to_float(input int n);
        int e;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        return {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [W-1:0] vec, input row_t r);
        logic [DW-1:0] d;
        d = '0;
        if (r.valid) d = (r.beat < N) ? vec[r.beat*DW +: DW] : 32'h3F80_0000;
        return d;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(o_ready), 64'd1);
        check({tag, "_valid"}, 64'(o_valid), 64'd0);
        check({tag, "_last"},  64'(o_last),  64'd0);
        check({tag, "_rd_en"}, 64'(o_weight_rd_en), 64'd0);
        check({tag, "_addr"},  64'(o_weight_addr), 64'd0);
        check({tag, "_data"},  64'(o_data), 64'd0);
    endtask

    task automatic start_frame(input logic [W-1:0] vec);
        @(negedge clk);
        check("start_ready", 64'(o_ready), 64'd1);
        i_valid = 1'b1;
        i_data  = vec;
        @(posedge clk);
    endtask

    // Called right after the accept edge; checks cycles T+1 .. T+stop_at.
    task automatic check_frame(input logic [W-1:0] vec, input bit busy, input bit keep_valid,
                               input logic [W-1:0] next_vec, input int stop_at);
        int n_valid;
        int n_last;
        n_valid = 0;
        n_last  = 0;
        for (int c = 1; c <= stop_at; c++) begin
            @(negedge clk);
            check($sformatf("c%0d_ready", c), 64'(o_ready), 64'(tbl[c].ready));
            check($sformatf("c%0d_rd_en", c), 64'(o_weight_rd_en), 64'(tbl[c].rd_en));
            if (tbl[c].rd_en) check($sformatf("c%0d_addr", c), 64'(o_weight_addr), 64'(tbl[c].addr));
            check($sformatf("c%0d_valid", c), 64'(o_valid), 64'(tbl[c].valid));
            check($sformatf("c%0d_last", c), 64'(o_last), 64'(tbl[c].last));
            check($sformatf("c%0d_data", c), 64'(o_data), 64'(exp_data(vec, tbl[c])));
            if (tbl[c].valid) begin
                check($sformatf("c%0d_weight", c), 64'(w_rdata), 64'(32'hA000_0000 | 32'(tbl[c].beat)));
            end
            if (o_valid) n_valid++;
            if (o_last)  n_last++;
            if (busy && (c == 10 || c == 34)) begin
                i_valid = 1'b1;
                i_data  = ~vec;
            end else if (keep_valid) begin
                i_valid = 1'b1;
                if (c == FRAME_CYCLES) i_data = next_vec;
            end else begin
                i_valid = 1'b0;
            end
        end
        if (stop_at == FRAME_CYCLES) begin
            check("frame_valid_count", 64'(n_valid), 64'(N + 1));
            check("frame_last_count",  64'(n_last),  64'd1);
        end
    endtask

    logic [W-1:0] vec_a;
    logic [W-1:0] vec_b;

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;

        for (int c = 1; c <= FRAME_CYCLES; c++) begin
            tbl[c].ready = (c == FRAME_CYCLES);
            tbl[c].rd_en = (c <= N + 1);
            tbl[c].addr  = (c <= N + 1) ? c - 1 : 0;
            tbl[c].valid = (c >= 2) && (c <= N + 2);
            tbl[c].last  = (c == N + 2);
            tbl[c].beat  = c - 2;
        end
        for (int k = 0; k < N; k++) begin
            vec_a[k*DW +: DW] = int_to_float(k + 1);
            vec_b[k*DW +: DW] = 32'h5A5A_0000 ^ (32'(k) * 32'h0101_0101);
        end

        // Reset asserted from time zero; outputs must be at reset values before the first edge.
        #3;
        check_reset_outputs("rst0");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single frame with act[k] = float(k+1).
        start_frame(vec_a);
        check_frame(vec_a, 1'b0, 1'b0, '0, FRAME_CYCLES);

        // Busy requests at T+10 and T+34 must be ignored.
        start_frame(vec_b);
        check_frame(vec_b, 1'b1, 1'b0, '0, FRAME_CYCLES);
        @(negedge clk);
        check("busy_no_accept_ready", 64'(o_ready), 64'd1);
        check("busy_no_accept_rd_en", 64'(o_weight_rd_en), 64'd0);

        // Back-to-back: i_valid held high, second frame accepted at the end of T+35.
        start_frame(vec_a);
        check_frame(vec_a, 1'b0, 1'b1, vec_b, FRAME_CYCLES);
        check_frame(vec_b, 1'b0, 1'b0, '0, FRAME_CYCLES);

        // Reset mid-frame at T+15, then a full frame after release.
        start_frame(vec_b);
        check_frame(vec_b, 1'b0, 1'b0, '0, 15);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        check_reset_outputs("midrst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(o_ready), 64'd1);
        check("post_rst_valid", 64'(o_valid), 64'd0);
        start_frame(vec_a);
        check_frame(vec_a, 1'b0, 1'b0, '0, FRAME_CYCLES);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
